// File: rtl/zet_div_seq.sv
// Iterative restoring divider for DIV/IDIV, word (32/16) and byte (16/8) operands.
// One quotient bit per clock through a single 17-bit subtract path.
module zet_div_seq #(
  parameter int unsigned Width = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 byte_op_i,
  input  logic                 sign_i,
  input  logic [2*Width-1:0]   a_i,
  input  logic [Width-1:0]     b_i,
  output logic [Width-1:0]     q_o,
  output logic [Width-1:0]     r_o,
  output logic                 ovf_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned Half = Width / 2;
  localparam int unsigned CntW = $clog2(Width) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDiv, StFix} state_e;

  state_e state_q, state_d;

  logic [2*Width-1:0] a_q;
  logic [Width-1:0]   b_q;
  logic               byte_q, sign_q;
  logic [Width:0]     rem_q;
  logic [Width-1:0]   lo_q, dvs_q;
  logic [CntW-1:0]    cnt_q;
  logic               qneg_q, rneg_q, ovf_pend_q;
  logic [Width-1:0]   q_q, r_q;
  logic               ovf_q, done_q;

  // Operand magnitudes and early overflow check, evaluated in LOAD
  logic               a_neg, b_neg;
  logic [Width-1:0]   a16, a16_mag, b16_mag;
  logic [Half-1:0]    b8, b8_mag;
  logic [2*Width-1:0] a32_mag;
  logic [Width-1:0]   ld_hi, ld_lo, ld_dvs;
  logic               ld_ovf;

  always_comb begin
    a16 = a_q[Width-1:0];
    b8  = b_q[Half-1:0];
    if (byte_q) begin
      a_neg = sign_q & a_q[Width-1];
      b_neg = sign_q & b_q[Half-1];
    end else begin
      a_neg = sign_q & a_q[2*Width-1];
      b_neg = sign_q & b_q[Width-1];
    end
    a16_mag = a_neg ? -a16 : a16;
    b8_mag  = b_neg ? -b8 : b8;
    a32_mag = a_neg ? -a_q : a_q;
    b16_mag = b_neg ? -b_q : b_q;
    // Byte dividend is left-aligned in the low half so the same shift loop applies
    if (byte_q) begin
      ld_hi  = {{Half{1'b0}}, a16_mag[Width-1:Half]};
      ld_lo  = {a16_mag[Half-1:0], {Half{1'b0}}};
      ld_dvs = {{Half{1'b0}}, b8_mag};
    end else begin
      ld_hi  = a32_mag[2*Width-1:Width];
      ld_lo  = a32_mag[Width-1:0];
      ld_dvs = b16_mag;
    end
    ld_ovf = (ld_dvs == '0) || (ld_hi >= ld_dvs);
  end

  // Trial subtract as add of inverted divisor with carry-in 1; carry-out means no borrow
  logic [Width:0]   shifted;
  logic [Width+1:0] trial;
  logic             no_borrow;

  always_comb begin
    shifted   = {rem_q[Width-1:0], lo_q[Width-1]};
    trial     = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(Width+1){1'b0}}, 1'b1};
    no_borrow = trial[Width+1];
  end

  logic [Width-1:0] q_mag, r_mag, q_sgn, r_sgn;
  logic             fix_ovf;

  always_comb begin
    q_mag = byte_q ? {{Half{1'b0}}, lo_q[Half-1:0]} : lo_q;
    r_mag = rem_q[Width-1:0];
    q_sgn = qneg_q ? -q_mag : q_mag;
    r_sgn = rneg_q ? -r_mag : r_mag;
    if (byte_q) begin
      q_sgn[Width-1:Half] = '0;
      r_sgn[Width-1:Half] = '0;
    end
    // Signed magnitude with the top bit set is out of range, including -0x8000/-0x80
    fix_ovf = ovf_pend_q | (sign_q & (byte_q ? q_mag[Half-1] : q_mag[Width-1]));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StLoad;
      StLoad: state_d = ld_ovf ? StFix : StDiv;
      StDiv:  if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = done_q;
    q_o    = q_q;
    r_o    = r_q;
    ovf_o  = ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q        <= '0;
      b_q        <= '0;
      byte_q     <= 1'b0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      lo_q       <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            byte_q <= byte_op_i;
            sign_q <= sign_i;
          end
        end
        StLoad: begin
          qneg_q     <= a_neg ^ b_neg;
          rneg_q     <= a_neg;
          ovf_pend_q <= ld_ovf;
          rem_q      <= {1'b0, ld_hi};
          lo_q       <= ld_lo;
          dvs_q      <= ld_dvs;
          cnt_q      <= byte_q ? CntW'(Half) : CntW'(Width);
        end
        StDiv: begin
          rem_q <= no_borrow ? trial[Width:0] : shifted;
          lo_q  <= {lo_q[Width-2:0], no_borrow};
          cnt_q <= cnt_q - CntW'(1);
        end
        StFix: begin
          q_q    <= fix_ovf ? '0 : q_sgn;
          r_q    <= fix_ovf ? '0 : r_sgn;
          ovf_q  <= fix_ovf;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zet_div_seq.sv
// Directed self-checking bench for zet_div_seq: latency, busy/done timing, signs, overflow, reset.
module tb_zet_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        byte_op = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] q, r;
  logic        ovf, busy, done;

  int passed = 0;
  int total = 0;
  int done_seen;

  zet_div_seq #(.Width(16)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .byte_op_i(byte_op),
    .sign_i   (sign),
    .a_i      (a),
    .b_i      (b),
    .q_o      (q),
    .r_o      (r),
    .ovf_o    (ovf),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; start is sampled at the next posedge (E0).
  // inj_edge > 0 drives a second start with other operands so it is sampled at that edge.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [15:0] tb_v,
                        input logic tbyte, input logic tsign, input int lat,
                        input logic [15:0] eq, input logic [15:0] er, input logic eovf,
                        input int inj_edge);
    a = ta;
    b = tb_v;
    byte_op = tbyte;
    sign = tsign;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s busy@0", tag), busy, 1'b1);
    for (int k = 1; k <= lat; k++) begin
      if (k == inj_edge) begin
        start = 1'b1;
        a = 32'h0000_0100;
        b = 16'h0007;
        byte_op = 1'b1;
        sign = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("%s done@%0d", tag, k), done, (k == lat));
      check($sformatf("%s busy@%0d", tag, k), busy, (k < lat));
    end
    check($sformatf("%s q", tag), q, eq);
    check($sformatf("%s r", tag), r, er);
    check($sformatf("%s ovf", tag), ovf, eovf);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst q", q, 16'h0);
    check("rst r", r, 16'h0);
    check("rst ovf", ovf, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("udiv_word", 32'h0001_0000, 16'h0003, 1'b0, 1'b0, 18, 16'h5555, 16'h0001, 1'b0, 0);

    // Results must hold while inputs wander with start low
    a = 32'hFFFF_FFFF;
    b = 16'h0000;
    byte_op = 1'b1;
    sign = 1'b1;
    repeat (3) @(negedge clk);
    check("hold q", q, 16'h5555);
    check("hold r", r, 16'h0001);
    check("hold ovf", ovf, 1'b0);
    check("hold done", done, 1'b0);

    run_op("idiv_word", 32'hFFFF_FFF9, 16'h0002, 1'b0, 1'b1, 18, 16'hFFFD, 16'hFFFF, 1'b0, 0);
    @(negedge clk);
    run_op("div_zero", 32'h0000_1234, 16'h0000, 1'b0, 1'b0, 2, 16'h0, 16'h0, 1'b1, 0);
    @(negedge clk);
    run_op("udiv_ovf", 32'h0002_0000, 16'h0002, 1'b0, 1'b0, 2, 16'h0, 16'h0, 1'b1, 0);
    @(negedge clk);
    run_op("udiv_byte", 32'hABCD_00FF, 16'hAB10, 1'b1, 1'b0, 10, 16'h000F, 16'h000F, 1'b0, 0);
    @(negedge clk);
    run_op("idiv_byte_ovf", 32'h0000_FF80, 16'h0001, 1'b1, 1'b1, 10, 16'h0, 16'h0, 1'b1, 0);
    @(negedge clk);
    run_op("idiv_word_ovf", 32'hFFFF_8000, 16'h0001, 1'b0, 1'b1, 18, 16'h0, 16'h0, 1'b1, 0);
    @(negedge clk);
    run_op("udiv_word_max", 32'hFFFE_0001, 16'hFFFF, 1'b0, 1'b0, 18, 16'hFFFF, 16'h0000, 1'b0, 0);
    @(negedge clk);
    run_op("idiv_byte_negb", 32'h0000_0064, 16'h00F9, 1'b1, 1'b1, 10, 16'h00F2, 16'h0002, 1'b0, 0);
    @(negedge clk);
    run_op("idiv_byte_nega", 32'h0000_FF9C, 16'h0007, 1'b1, 1'b1, 10, 16'h00F2, 16'h00FE, 1'b0, 0);
    @(negedge clk);

    // Start at edge 5 ignored, then a start in the done cycle is accepted
    run_op("busy_ignore", 32'h0001_0000, 16'h0003, 1'b0, 1'b0, 18, 16'h5555, 16'h0001, 1'b0, 5);
    run_op("back2back", 32'h0000_0064, 16'hFFF9, 1'b0, 1'b1, 18, 16'hFFF2, 16'h0002, 1'b0, 0);
    @(negedge clk);

    // Abort a word divide with reset before edge 7
    a = 32'h0001_0000;
    b = 16'h0003;
    byte_op = 1'b0;
    sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort q", q, 16'h0);
    check("abort r", r, 16'h0);
    check("abort ovf", ovf, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort no_done", done_seen, 0);
    check("abort idle", busy, 1'b0);
    @(negedge clk);
    run_op("after_reset", 32'hFFFF_FFF9, 16'h0002, 1'b0, 1'b1, 18, 16'hFFFD, 16'hFFFF, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zet_div_seq.md
Name: zet_div_seq

Overview:
- Iterative restoring divider for the Zet execution unit. Implements DIV/IDIV for word (32/16) and byte (16/8) operands.
- Produces one quotient bit per clock using a single 17-bit subtract path, the same subtract form as the existing 16-bit adder primitive (carry-in 1, inverted operand).
- Sits downstream of the operand muxes: the register file and memory operands arrive through the mux stage.
- Feeds quotient and remainder back to the writeback muxes. Raises a divide-error flag for the #DE exception logic.

Parameters:
- WIDTH, 16, word operand width. The dividend is 2*WIDTH. The byte mode width is fixed at WIDTH/2.

Ports:
- clk      input   1   core clock, rising edge
- rst      input   1   asynchronous, active-low reset; asserting it forces the reset state immediately
- start    input   1   request; sampled only in IDLE
- byte_op  input   1   1 = 16/8 divide, 0 = 32/16 divide; sampled with start
- sign     input   1   1 = IDIV (two's complement), 0 = DIV; sampled with start
- a        input   32  dividend; byte mode uses a[15:0] only
- b        input   16  divisor; byte mode uses b[7:0] only
- q        output  16  quotient; byte mode puts it in q[7:0] with q[15:8]=0
- r        output  16  remainder; byte mode puts it in r[7:0] with r[15:8]=0
- ovf      output  1   divide error: zero divisor or quotient out of range
- busy     output  1   high from the cycle after start is accepted until done
- done     output  1   single-cycle completion pulse

Behaviour:
- Reset: q=0, r=0, ovf=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Reset asserted mid-operation aborts the operation. No done is issued after reset release.
- States: IDLE -> LOAD -> DIV -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 latches a, b, byte_op and sign, then goes to LOAD with busy=1.
  - start=0 stays in IDLE.
- start while busy (LOAD/DIV/FIX) is ignored. It is not queued.
- LOAD (edge E1):
  - Take magnitudes |a| and |b| when sign=1. Remember the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Early-overflow check, unsigned on magnitudes: divisor==0, or upper half of |dividend| >= |divisor|.
  - If early overflow: go directly to FIX with the overflow flag set.
  - Otherwise load the partial remainder with the upper half, set counter N = 16 (word) or 8 (byte), and go to DIV.
- DIV, once per cycle:
  - Shift {partial remainder, lower dividend} left by one. The partial remainder is held at 17 bits.
  - Trial subtract the divisor.
  - If there is no borrow, keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Decrement the counter. When it reaches 1 on this step, go to FIX.
- FIX, one cycle:
  - Apply the signs: negate the quotient if the quotient sign is set; negate the remainder if the dividend was negative. IDIV truncates toward zero and the remainder takes the dividend's sign.
  - Signed range check follows 8086 rules. Valid magnitude is 0..0x7FFF (word) or 0..0x7F (byte). A negative result of -0x8000 or -0x80 is also an overflow.
  - Register q, r and ovf. On ovf, q=0 and r=0.
  - Pulse done=1 for one cycle and drop busy with that same cycle.
- Latency from start edge E0 to done:
  - Word: done high in the cycle after edge 18.
  - Byte: done high in the cycle after edge 10.
  - Early overflow: done high in the cycle after edge 2.
- Output stability: q, r and ovf hold their values from the done cycle until the next done pulse. They are unaffected by input changes meanwhile.
- Back-to-back operation: start may be asserted in the done cycle and is accepted, because the state is IDLE in that cycle.

Test Plan:
1. Unsigned word: a=0x0001_0000, b=0x0003, sign=0, byte_op=0 -> q=0x5555, r=0x0001, ovf=0. done in the cycle after edge 18; busy high for edges 1..18.
2. Signed word: a=0xFFFF_FFF9 (-7), b=0x0002, sign=1 -> q=0xFFFD (-3), r=0xFFFF (-1), ovf=0.
3. Divide by zero, and unsigned overflow:
   - b=0x0000 -> ovf=1, q=0, r=0, done after edge 2.
   - a=0x0002_0000, b=0x0002, sign=0 -> ovf=1 via early check, done after edge 2.
4. Byte mode:
   - a=0x00FF, b=0x0010, sign=0, byte_op=1 -> q=0x000F, r=0x000F, done after edge 10.
   - a=0xFF80 (-128), b=0x0001, sign=1, byte_op=1 -> ovf=1 (8086 range rule).
5. Busy handling:
   - A second start with different operands at edge 5 of a word divide is ignored; the result matches the first operands.
   - start asserted in the done cycle is accepted; the second done arrives 18 cycles later.
6. Reset: rst low at edge 7 of a word divide -> q, r, ovf, busy and done are 0 immediately. No done is issued after release. A new start then completes normally.
